// File: rtl/send_packet_scheduler.sv
// Round-robin scheduler: drains one of two packet FIFOs word by word over a four-phase TX_REQ/TX_ACK link.
// Latency: grant at the first edge with a valid descriptor, TX_REQ two edges after data is present; stalls in SETUP on an empty FIFO.
module send_packet_scheduler #(
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt0_valid,
  input  logic        pkt1_valid,
  input  logic [1:0]  pkt0_dir,
  input  logic [1:0]  pkt1_dir,
  input  logic [7:0]  pkt0_len,
  input  logic [7:0]  pkt1_len,
  output logic        pkt0_ack,
  output logic        pkt1_ack,
  input  logic        dat0_empty,
  input  logic        dat1_empty,
  input  logic [15:0] dat0_data,
  input  logic [15:0] dat1_data,
  output logic        dat0_rd,
  output logic        dat1_rd,
  output logic [15:0] TX_DATA,
  output logic        TX_REQ,
  input  logic        TX_ACK,
  output logic [1:0]  DIRECTION,
  output logic        SEND_DONE,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, WAIT_ACK, WAIT_NACK, DONE, ABORT} state_t;

  state_t         state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           last_q, last_d;
  logic           loaded_q, loaded_d;
  logic [7:0]     rem_q, rem_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic [15:0]    tx_data_q, tx_data_d;
  logic           tx_req_q, tx_req_d;
  logic [1:0]     dir_q, dir_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic [1:0]     ack_q, ack_d;
  logic [1:0]     rd_q, rd_d;

  logic           sel_empty;
  logic [15:0]    sel_data;
  logic           pick;
  logic [1:0]     gnt_onehot;

  assign sel_empty  = gnt_q ? dat1_empty : dat0_empty;
  assign sel_data   = gnt_q ? dat1_data : dat0_data;
  // Last-granted requester loses a tie.
  assign pick       = (pkt0_valid && pkt1_valid) ? ~last_q : pkt1_valid;
  assign gnt_onehot = gnt_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    loaded_d  = loaded_q;
    rem_d     = rem_q;
    to_cnt_d  = to_cnt_q;
    tx_data_d = tx_data_q;
    tx_req_d  = tx_req_q;
    dir_d     = dir_q;
    err_d     = err_q & ~err_clr;
    ack_d     = 2'b00;
    rd_d      = 2'b00;

    case (state_q)
      IDLE: begin
        if (pkt0_valid || pkt1_valid) begin
          gnt_d    = pick;
          last_d   = pick;
          dir_d    = pick ? pkt1_dir : pkt0_dir;
          rem_d    = pick ? pkt1_len : pkt0_len;
          ack_d    = pick ? 2'b10 : 2'b01;
          loaded_d = 1'b0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (loaded_q) begin
          tx_req_d = 1'b1;
          to_cnt_d = '0;
          loaded_d = 1'b0;
          state_d  = WAIT_ACK;
        end else if (!sel_empty) begin
          tx_data_d = sel_data;
          rd_d      = gnt_onehot;
          loaded_d  = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (TX_ACK) begin
          tx_req_d = 1'b0;
          to_cnt_d = '0;
          state_d  = WAIT_NACK;
        end else if (to_cnt_q == TO_LAST) begin
          tx_req_d = 1'b0;
          err_d    = 1'b1;
          rem_d    = rem_q - 8'd1;
          state_d  = ABORT;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      WAIT_NACK: begin
        if (!TX_ACK) begin
          rem_d   = rem_q - 8'd1;
          state_d = (rem_q == 8'd1) ? DONE : SETUP;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          rem_d   = rem_q - 8'd1;
          state_d = ABORT;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ABORT: begin
        // rd is registered, so skip a cycle after each pop until empty reflects it.
        if (rem_q == 8'd0) begin
          state_d = IDLE;
        end else if (!sel_empty && (rd_q == 2'b00)) begin
          rd_d  = gnt_onehot;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      loaded_q  <= 1'b0;
      rem_q     <= 8'd0;
      to_cnt_q  <= '0;
      tx_data_q <= 16'd0;
      tx_req_q  <= 1'b0;
      dir_q     <= 2'b00;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 2'b00;
      rd_q      <= 2'b00;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      loaded_q  <= loaded_d;
      rem_q     <= rem_d;
      to_cnt_q  <= to_cnt_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
      rd_q      <= rd_d;
    end
  end

  assign pkt0_ack    = ack_q[0];
  assign pkt1_ack    = ack_q[1];
  assign dat0_rd     = rd_q[0];
  assign dat1_rd     = rd_q[1];
  assign TX_DATA     = tx_data_q;
  assign TX_REQ      = tx_req_q;
  assign DIRECTION   = dir_q;
  assign SEND_DONE   = done_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: doc/send_packet_scheduler.md
SEND_PACKET_SCHEDULER -- requirements
Module: send_packet_scheduler

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1023: cycles allowed in either ACK wait state before the packet is aborted.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 pkt0_valid / pkt1_valid  in  1  requester has a packet descriptor pending.
REQ-005 pkt0_dir / pkt1_dir  in  2  target direction: 00=E, 01=S, 10=W, 11=N.
REQ-006 pkt0_len / pkt1_len  in  8  packet length in 16-bit words; 0 means 256.
REQ-007 pkt0_ack / pkt1_ack  out  1  one-cycle pulse: descriptor accepted.
REQ-008 dat0_empty / dat1_empty  in  1  first-word-fall-through data FIFO empty flag.
REQ-009 dat0_data / dat1_data  in  16  FIFO head word.
REQ-010 dat0_rd / dat1_rd  out  1  one-cycle pop pulse.
REQ-011 TX_DATA  out  16  word to the direction selector.
REQ-012 TX_REQ  out  1  four-phase request.
REQ-013 TX_ACK  in  1  four-phase acknowledge, already synchronous to clk.
REQ-014 DIRECTION  out  2  direction select, same encoding as pkt_dir.
REQ-015 SEND_DONE  out  1  one-cycle pulse: packet completed normally.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 timeout_err  out  1  sticky abort flag.
REQ-018 err_clr  in  1  clears timeout_err.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, WAIT_ACK, WAIT_NACK, DONE and ABORT; all outputs are registered.
REQ-020 IDLE: when any pkt_valid is high, grant round-robin, with the last-granted requester at lowest priority (requester 0 wins after reset); latch dir and len; pulse pktK_ack; load DIRECTION on the same edge; go to SETUP.
REQ-021 SETUP: wait while datK_empty=1; otherwise load TX_DATA<=datK_data and pulse datK_rd; on the next edge set TX_REQ=1 and go to WAIT_ACK.
REQ-022 TX_DATA and DIRECTION SHALL be stable for at least one cycle before TX_REQ rises and for as long as TX_REQ stays high.
REQ-023 WAIT_ACK: on TX_ACK=1, set TX_REQ<=0 and go to WAIT_NACK.
REQ-024 WAIT_NACK: on TX_ACK=0, decrement the 8-bit remaining count; if the pre-decrement value was 1, go to DONE; otherwise go to SETUP.
REQ-025 len=0 SHALL load 0 into the remaining count, so the count wraps and exactly 256 words are sent.
REQ-026 DONE: pulse SEND_DONE for one cycle, then go to IDLE; the next descriptor can be accepted no earlier than the cycle after DONE.
REQ-027 Timeout counter: cleared on entry to WAIT_ACK and to WAIT_NACK; increments each cycle in those states.
REQ-028 When the timeout counter reaches ACK_TIMEOUT: TX_REQ<=0, timeout_err<=1, go to ABORT.
REQ-029 ABORT: pop the granted FIFO one word per cycle while not empty until the packet's remaining words (excluding the word in flight) are consumed, then go to IDLE; SEND_DONE is not asserted.
REQ-030 In ABORT, if the FIFO is empty, wait; the abort completes only when all remaining words are drained.
REQ-031 If err_clr and a timeout occur in the same cycle, set timeout_err SHALL win.
REQ-032 pkt_valid changes on the non-granted requester during a packet SHALL have no effect until IDLE.
REQ-033 Never pulse datK_rd or pktK_ack for the non-granted requester.

Reset
REQ-034 While rst=1: state=IDLE; TX_DATA=0; TX_REQ=0; DIRECTION=00; SEND_DONE=0; busy=0; all ack and rd outputs=0; timeout_err=0; round-robin pointer=requester 0.
REQ-035 Reset asserted mid-packet SHALL abandon the packet immediately, with no FIFO drain; the requester is responsible for its own flush.

Verification
V-1 Single packet, pkt0 dir=10, len=3, ACK responder with 3-cycle latency -> 3 four-phase handshakes; DIRECTION=10 throughout; words in FIFO order; one SEND_DONE pulse; 3 dat0_rd pulses.
V-2 Both valid continuously, len=1 each -> grants alternate 0,1,0,1; no two consecutive grants to the same requester.
V-3 len=0 -> exactly 256 handshakes, then SEND_DONE.
V-4 ACK held low, ACK_TIMEOUT=15, len=4 -> TX_REQ drops 15 cycles after rising; timeout_err=1; 3 further rd pulses; no SEND_DONE; busy low afterwards.
V-5 FIFO empty after word 1 of a len=2 packet -> FSM holds in SETUP with TX_REQ=0; resumes when data arrives; SEND_DONE after word 2.
V-6 rst asserted while in WAIT_ACK -> all outputs take their reset values asynchronously; after release, a new packet transfers normally.
